// File: rtl/pathsy_pipe_pkg.sv
// rtl/pathsy_pipe_pkg.sv - shared width helper and error-flag type for pipeline output buffers
package pathsy_pipe_pkg;

    function automatic int count_width(input int entries);
        return $clog2(entries + 1);
    endfunction

    typedef struct packed {
        logic unexpected;
        logic overflow;
    } err_flags_t;

endpackage

// File: rtl/pipe_output_buffer_if.sv
// rtl/pipe_output_buffer_if.sv - issue credit, result input and buffered output signals
interface pipe_output_buffer_if
    import pathsy_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = count_width(DEPTH);

    logic             issue_ready;
    logic             issue_valid;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             err_unexpected;
    logic             err_overflow;

    modport master (
        input  issue_ready, out_valid, out_data, count, err_unexpected, err_overflow,
        output issue_valid, in_valid, in_data, out_ready
    );

    modport slave (
        output issue_ready, out_valid, out_data, count, err_unexpected, err_overflow,
        input  issue_valid, in_valid, in_data, out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with occupancy count, data array unreset
module sync_fifo
    import pathsy_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [count_width(DEPTH)-1:0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Push at full is legal only alongside a pop; the caller guarantees that.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_output_buffer.sv
// rtl/pipe_output_buffer.sv - credit-based elastic buffer behind a fixed-latency, non-stallable pipeline
module pipe_output_buffer
    import pathsy_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_output_buffer_if.slave  bus
);
    localparam int CW = count_width(DEPTH);
    localparam int DW = $clog2(LATENCY + 1);

    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [DW-1:0]    drain;
    logic [CW:0]      credits_used;
    logic [WIDTH-1:0] head_data;
    err_flags_t       err;
    logic             in_window;
    logic             full;
    logic             not_empty;
    logic             issue;
    logic             pop;
    logic             push;
    logic             hit_unexpected;
    logic             hit_overflow;

    assign in_window    = (drain != '0);
    assign full         = (count == CW'(DEPTH));
    assign not_empty    = (count != '0);
    assign credits_used = {1'b0, count} + {1'b0, inflight};

    // Every issued result owns a slot until it is popped, so the pipeline never needs to stall.
    assign bus.issue_ready = rst_n & ~in_window & (credits_used < (CW + 1)'(DEPTH));
    assign issue           = bus.issue_valid & bus.issue_ready;
    assign pop             = not_empty & bus.out_ready;

    assign hit_unexpected = bus.in_valid & ~in_window & (inflight == '0);
    assign hit_overflow   = bus.in_valid & ~in_window & full & ~pop;
    assign push           = bus.in_valid & ~in_window & ~hit_unexpected & ~hit_overflow;

    // The delay line has no reset, so results issued before reset are discarded for LATENCY cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
            drain    <= DW'(LATENCY);
            err      <= '0;
        end else begin
            if (in_window) begin
                drain <= drain - DW'(1);
            end
            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
            if (hit_unexpected) begin
                err.unexpected <= 1'b1;
            end
            if (hit_overflow) begin
                err.overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.in_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign bus.out_valid      = not_empty;
    assign bus.out_data       = head_data;
    assign bus.count          = count;
    assign bus.err_unexpected = err.unexpected;
    assign bus.err_overflow   = err.overflow;

endmodule
